updown_counter_n: RTL and testbench

Parametrised reversible counter with built-in step prescaler, synchronous parallel load, programmable modulus, and terminal-count/carry outputs. Generalises the fixed 16-bit 1 Hz up/down counter used on the lab board. Sits between the board clock and the display/cascade logic. Multiple instances cascade through `co` → `en` to build wider or multi-digit counters.

---
 rtl/updown_counter_n.sv | 87 ++++++++
 tb/tb_updown_counter_n.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - parametrised up/down counter with step prescaler, load, modulus and carry
// Build macro UDCNT_SAT_EN selects saturating mode; default build wraps and pulses co.
module updown_counter_n #(
  parameter int     WIDTH    = 16,
  parameter longint MAX      = (longint'(1) << WIDTH) - 1,
  parameter int     DIV      = 50_000_000,
  parameter int     CNT_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             rc,
  output logic             co
);

  localparam int               PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(CNT_INIT);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]    pre;
  logic             pre_last;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] din_clamped;

  assign pre_last    = (pre == PRE_LAST);
  assign tick        = en & pre_last;
  assign at_max      = (cnt == MAX_V);
  assign at_zero     = (cnt == '0);
  assign rc          = s ? at_zero : at_max;
  assign din_clamped = (din > MAX_V) ? MAX_V : din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= INIT_V;
      pre <= '0;
      co  <= 1'b0;
    end else if (ld) begin
      // A load also restarts the prescaler, so the next step is a full DIV away.
      cnt <= din_clamped;
      pre <= '0;
      co  <= 1'b0;
    end else begin
      if (en) begin
        pre <= pre_last ? '0 : pre + PW'(1);
      end
      if (tick) begin
        if (!s) begin
          if (at_max) begin
`ifdef UDCNT_SAT_EN
            cnt <= MAX_V;
            co  <= 1'b0;
`else
            cnt <= '0;
            co  <= 1'b1;
`endif
          end else begin
            cnt <= cnt + WIDTH'(1);
            co  <= 1'b0;
          end
        end else begin
          if (at_zero) begin
`ifdef UDCNT_SAT_EN
            cnt <= '0;
            co  <= 1'b0;
`else
            cnt <= MAX_V;
            co  <= 1'b1;
`endif
          end else begin
            cnt <= cnt - WIDTH'(1);
            co  <= 1'b0;
          end
        end
      end else begin
        co <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - directed self-checking bench for updown_counter_n
module tb_updown_counter_n;

`ifdef UDCNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, s = 1'b0, ld = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] cnt;
  logic       tick, rc, co;

  logic       en1 = 1'b0, s1 = 1'b0, ld1 = 1'b0;
  logic [3:0] din1 = '0;
  logic [3:0] cnt1;
  logic       tick1, rc1, co1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(4), .MAX(9), .DIV(4), .CNT_INIT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .ld(ld), .din(din),
    .cnt(cnt), .tick(tick), .rc(rc), .co(co)
  );

  updown_counter_n #(.WIDTH(4), .MAX(9), .DIV(1), .CNT_INIT(0)) u_div1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .s(s1), .ld(ld1), .din(din1),
    .cnt(cnt1), .tick(tick1), .rc(rc1), .co(co1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  // Advance until tick is seen (bounded), then take the stepping edge.
  task automatic wait_tick(input string tag);
    int n = 0;
    while (tick !== 1'b1 && n < 8) begin
      next();
      n++;
    end
    check({tick_tag(tag), "_seen"}, 32'(tick), 32'd1);
    next();
  endtask

  function automatic string tick_tag(input string tag);
    return {"tick_", tag};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_rc_up", 32'(rc), 32'd0);
    s = 1'b1;
    #1;
    check("rst_rc_down", 32'(rc), 32'd1);
    s = 1'b0;
    next();

    rst_n = 1'b1;
    en = 1'b1;
    for (int step = 1; step <= 10; step++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("up_tick_%0d_%0d", step, c), 32'(tick), (c == 3) ? 32'd1 : 32'd0);
        next();
      end
      if (step < 10) begin
        check($sformatf("up_cnt_%0d", step), 32'(cnt), 32'(step));
        check($sformatf("up_co_%0d", step), 32'(co), 32'd0);
        check($sformatf("up_rc_%0d", step), 32'(rc), (step == 9) ? 32'd1 : 32'd0);
      end
    end
    check("wrap_cnt", 32'(cnt), SAT ? 32'd9 : 32'd0);
    check("wrap_co", 32'(co), SAT ? 32'd0 : 32'd1);
    next();
    check("wrap_co_drop", 32'(co), 32'd0);

    ld = 1'b1; din = 4'd0;
    next();
    ld = 1'b0; s = 1'b1;
    #1;
    check("down_ld0_cnt", 32'(cnt), 32'd0);
    check("down_rc_at0", 32'(rc), 32'd1);
    wait_tick("down_wrap");
    check("down_wrap_cnt", 32'(cnt), SAT ? 32'd0 : 32'd9);
    check("down_wrap_co", 32'(co), SAT ? 32'd0 : 32'd1);
    check("down_wrap_rc", 32'(rc), SAT ? 32'd1 : 32'd0);
    wait_tick("down_2");
    check("down_2_cnt", 32'(cnt), SAT ? 32'd0 : 32'd8);
    check("down_2_co", 32'(co), 32'd0);

    begin
      int n = 0;
      while (tick !== 1'b1 && n < 8) begin
        next();
        n++;
      end
      check("ld_tick_align", 32'(tick), 32'd1);
    end
    ld = 1'b1; din = 4'd7;
    next();
    ld = 1'b0;
    #1;
    check("ld_cnt", 32'(cnt), 32'd7);
    check("ld_co", 32'(co), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("ld_restart_tick_%0d", c), 32'(tick), (c == 3) ? 32'd1 : 32'd0);
      next();
    end
    check("ld_then_step", 32'(cnt), 32'd6);

    ld = 1'b1; din = 4'd15;
    next();
    ld = 1'b0;
    #1;
    check("ld_clamp", 32'(cnt), 32'd9);

    next();
    next();
    en = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold_tick_%0d", c), 32'(tick), 32'd0);
      check($sformatf("hold_cnt_%0d", c), 32'(cnt), 32'd9);
      check($sformatf("hold_co_%0d", c), 32'(co), 32'd0);
      next();
    end
    en = 1'b1;
    #1;
    check("resume_tick0", 32'(tick), 32'd0);
    next();
    check("resume_tick1", 32'(tick), 32'd1);
    next();
    check("resume_cnt", 32'(cnt), 32'd8);

    ld = 1'b1; din = 4'd5;
    next();
    ld = 1'b0;
    next();
    next();
    check("pre_rst_cnt", 32'(cnt), 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(cnt), 32'd0);
    check("async_rst_co", 32'(co), 32'd0);
    next();
    rst_n = 1'b1;
    en = 1'b0;

    en1 = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("div1_tick_%0d", c), 32'(tick1), 32'd1);
      next();
      check($sformatf("div1_cnt_%0d", c), 32'(cnt1), 32'(c));
    end
    en1 = 1'b0;
    #1;
    check("div1_tick_off", 32'(tick1), 32'd0);
    next();
    check("div1_hold", 32'(cnt1), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
